hazard_stall_ctrl: RTL and testbench

- Central pipeline sequencer for the 5-stage RISC-V core.
- Generates per-stage register enables, flushes and bubbles. Handles load-use hazards that forwarding cannot cover, taken-branch/jump redirects, multi-cycle mul/div occupancy of EX, and data-memory wait states.
- Sits beside the forwarding logic in the EX/ID region. Drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

---
 rtl/hazard_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: stage enables, flushes and bubbles.
// Optional 32-bit stall counter output is built when HAZARD_STALL_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic       ex_redirect,
  input  logic       ex_md_start,
  input  logic       md_done,
  input  logic       mem_req,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       exmem_bubble,
  output logic       busy,
  output logic       md_timeout
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_count
`endif
);

  typedef enum logic [0:0] {RUN = 1'b0, MD_WAIT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] md_cnt;
  logic             mem_freeze;
  logic             load_use;
  logic             md_expire;

  assign mem_freeze = mem_req && !dmem_ready;
  assign load_use   = ex_memread && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));
  assign md_expire  = (state == MD_WAIT) && !md_done && (md_cnt == CNT_LAST);
  assign busy       = (state == MD_WAIT);

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    idex_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    if (mem_freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if ((state == MD_WAIT) && !md_done && !md_expire) begin
      // Hold the front end while older instructions drain behind a bubble.
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_bubble = 1'b1;
    end else if ((state == RUN) && ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if ((state == RUN) && load_use) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      md_cnt     <= '0;
      md_timeout <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (ex_md_start && !mem_freeze) begin
            state  <= MD_WAIT;
            md_cnt <= '0;
          end
        end
        MD_WAIT: begin
          if (!mem_freeze && md_done) begin
            state <= RUN;
          end else if (!mem_freeze && md_expire) begin
            state      <= RUN;
            md_timeout <= 1'b1;
          end else if (md_cnt != CNT_LAST) begin
            // Saturate at the release count so a freeze cannot skip the timeout.
            md_cnt <= md_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (!pc_en) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus random stimulus against
// a cycle model built from the stall/flush rules.
module tb_hazard_stall_ctrl;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_memread = 0, ex_redirect = 0;
  logic       ex_md_start = 0, md_done = 0, mem_req = 0, dmem_ready = 0;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic       ifid_flush, idex_bubble, exmem_bubble, busy, md_timeout;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_count;
  logic [31:0] m_stalls;
`endif

  int vectors = 0;
  int errors  = 0;

  // Model state: waiting on mul/div, cycles already spent waiting, sticky timeout.
  bit m_wait;
  int m_cycles;
  bit m_to;

  logic [9:0] outs;
  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_bubble, exmem_bubble, busy, md_timeout};

  hazard_stall_ctrl #(.MD_TIMEOUT(T), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .ex_md_start(ex_md_start), .md_done(md_done), .mem_req(mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .busy(busy), .md_timeout(md_timeout)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] model_out();
    bit frz, lu, rel;
    frz = mem_req && !dmem_ready;
    lu  = ex_memread && ex_rd != 0 &&
          ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
    rel = md_done || (m_cycles == T - 1);
    if (frz)               return {5'b00000, 3'b000, m_wait, m_to};
    if (m_wait && !rel)    return {5'b00011, 3'b001, 1'b1, m_to};
    if (m_wait)            return {5'b11111, 3'b000, 1'b1, m_to};
    if (ex_redirect)       return {5'b11111, 3'b110, 1'b0, m_to};
    if (lu)                return {5'b00111, 3'b010, 1'b0, m_to};
    return {5'b11111, 3'b000, 1'b0, m_to};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait = 0; m_cycles = 0; m_to = 0;
`ifdef HAZARD_STALL_CNT_EN
      m_stalls = '0;
`endif
    end else begin
      bit frz;
      logic [9:0] e;
      e   = model_out();
      frz = mem_req && !dmem_ready;
`ifdef HAZARD_STALL_CNT_EN
      if (!e[9]) m_stalls = m_stalls + 32'd1;
`endif
      if (m_wait) begin
        if (!frz && md_done) m_wait = 0;
        else if (!frz && m_cycles == T - 1) begin m_wait = 0; m_to = 1; end
        else if (m_cycles < T - 1) m_cycles = m_cycles + 1;
      end else if (ex_md_start && !frz) begin
        m_wait = 1; m_cycles = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [9:0] e;
    e = model_out();
    vectors++;
    if (outs !== e) begin
      errors++;
      $display("FAIL model_cmp t=%0t got=%b exp=%b", $time, outs, e);
    end
`ifdef HAZARD_STALL_CNT_EN
    vectors++;
    if (stall_count !== m_stalls) begin
      errors++;
      $display("FAIL stall_count t=%0t got=%0d exp=%0d", $time, stall_count, m_stalls);
    end
`endif
  end

  task automatic chk(input string name, input logic [9:0] exp);
    vectors++;
    if (outs !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b exp=%b", name, $time, outs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; ex_rd = 0;
    ex_memread = 0; ex_redirect = 0; ex_md_start = 0; md_done = 0;
    mem_req = 0; dmem_ready = 0;
  endtask

  localparam logic [9:0] DEF   = 10'b11111_000_0_0;
  localparam logic [9:0] MDST  = 10'b00011_001_1_0;
  localparam logic [9:0] MDREL = 10'b11111_000_1_0;

  initial begin
    idle();
    #12;
    chk("reset_state", DEF);
    step(); rst_n = 1;

    // Load-use on rs2
    step(); ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    @(negedge clk); chk("load_use", 10'b00111_010_0_0);
    step(); idle();
    @(negedge clk); chk("load_use_next", DEF);
    step(); ex_memread = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
    @(negedge clk); chk("load_use_x0", DEF);

    // Redirect beats load-use
    step(); ex_memread = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1; ex_redirect = 1;
    @(negedge clk); chk("redirect_lu", 10'b11111_110_0_0);

    // Mul/div completing after 10 wait cycles
    step(); idle(); ex_md_start = 1;
    @(negedge clk); chk("md_entry", DEF);
    step(); ex_md_start = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("md_wait", MDST);
      step();
    end
    md_done = 1;
    @(negedge clk); chk("md_done", MDREL);
    step(); md_done = 0;
    @(negedge clk); chk("md_after", DEF);

    // Memory freeze holds off mul/div entry
    step(); ex_md_start = 1; mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("freeze_md", 10'b00000_000_0_0);
      step();
    end
    dmem_ready = 1;
    @(negedge clk); chk("freeze_release", DEF);
    step(); idle();
    @(negedge clk); chk("md_after_freeze", MDST);
    step(); md_done = 1;
    @(negedge clk); chk("md_done2", MDREL);

    // Timeout release on the T-th wait cycle
    step(); idle(); ex_md_start = 1;
    step(); ex_md_start = 0;
    for (int i = 0; i < T - 1; i++) begin
      @(negedge clk); chk("to_wait", MDST);
      step();
    end
    @(negedge clk); chk("to_release", MDREL);
    step();
    @(negedge clk); chk("to_sticky", 10'b11111_000_0_1);
    step(); step();
    @(negedge clk); chk("to_sticky2", 10'b11111_000_0_1);

    // Reset in the 4th wait cycle
    step(); ex_md_start = 1;
    step(); ex_md_start = 0;
    step(); step(); step();
    @(negedge clk); chk("pre_reset_wait", 10'b00011_001_1_1);
    #2 rst_n = 0; #1;
    chk("reset_mid_wait", DEF);
`ifdef HAZARD_STALL_CNT_EN
    vectors++;
    if (stall_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_stall_count got=%0d exp=0", stall_count);
    end
`endif
    step(); rst_n = 1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      ex_rd       = 5'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom_range(0, 1));
      id_use_rs2  = 1'($urandom_range(0, 1));
      ex_memread  = ($urandom_range(0, 2) == 0);
      ex_redirect = ($urandom_range(0, 7) == 0);
      ex_md_start = ($urandom_range(0, 9) == 0);
      md_done     = ($urandom_range(0, 24) == 0);
      mem_req     = ($urandom_range(0, 2) == 0);
      dmem_ready  = ($urandom_range(0, 9) < 7);
    end
    step(); idle();
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
